// File: rtl/cim_timestep_sequencer.sv
// cim_timestep_sequencer: runs one WL bit-plane through the CIM macro (latch, compute, 2N-channel ADC scan, pos-neg diff)
// Ports: clk/rst_n clock and async active-low reset; wl_in/wl_in_valid/wl_in_ready upstream bit-plane;
// wl_spike/dac_valid/cim_start/cim_done/adc_start/adc_done/bl_sel/bl_data macro control and readout;
// diff_data/diff_valid/diff_ready downstream signed diffs; busy status; err_timeout/err_clr sticky timeout flag.
module cim_timestep_sequencer #(
  parameter int P_NUM_INPUTS     = 64,
  parameter int P_NUM_OUTPUTS    = 10,
  parameter int P_ADC_BITS       = 8,
  parameter int P_TIMEOUT_CYCLES = 255
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [P_NUM_INPUTS-1:0]                    wl_in,
  input  logic                                       wl_in_valid,
  output logic                                       wl_in_ready,
  output logic [P_NUM_INPUTS-1:0]                    wl_spike,
  output logic                                       dac_valid,
  output logic                                       cim_start,
  input  logic                                       cim_done,
  output logic                                       adc_start,
  input  logic                                       adc_done,
  output logic [$clog2(2*P_NUM_OUTPUTS)-1:0]         bl_sel,
  input  logic [P_ADC_BITS-1:0]                      bl_data,
  output logic                                       diff_valid,
  input  logic                                       diff_ready,
  output logic [P_NUM_OUTPUTS*(P_ADC_BITS+1)-1:0]    diff_data,
  output logic                                       busy,
  output logic                                       err_timeout,
  input  logic                                       err_clr
);
  localparam int LP_CH = 2 * P_NUM_OUTPUTS;
  localparam int LP_SW = $clog2(LP_CH);
  localparam int LP_DW = P_ADC_BITS + 1;
  localparam int LP_TW = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [LP_SW-1:0] LP_LAST = LP_SW'(LP_CH - 1);
  localparam logic [LP_TW-1:0] LP_TMAX = LP_TW'(P_TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CSTART, S_CWAIT, S_ASTART, S_AWAIT, S_DIFF, S_OUT} state_t;
  state_t                              r_state;
  logic [P_NUM_INPUTS-1:0]             r_wl;
  logic [LP_SW-1:0]                    r_sel;
  logic [LP_TW-1:0]                    r_timer;
  logic [P_ADC_BITS-1:0]               r_raw [LP_CH];
  logic [P_NUM_OUTPUTS*LP_DW-1:0]      r_diff;
  logic                                r_dac, r_cim, r_adc, r_dv, r_err;
  assign wl_in_ready = r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign wl_spike    = r_wl;
  assign dac_valid   = r_dac;
  assign cim_start   = r_cim;
  assign adc_start   = r_adc;
  assign bl_sel      = r_sel;
  assign diff_valid  = r_dv;
  assign diff_data   = r_diff;
  assign err_timeout = r_err;
  // Pulse outputs are set on entry to their state, so each is high for exactly that state's single cycle.
  // A timeout abandons the plane: raw/diff stay untouched and OUT is never reached.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wl    <= '0;
      r_sel   <= '0;
      r_timer <= '0;
      r_raw   <= '{default: '0};
      r_diff  <= '0;
      r_dac   <= 1'b0;
      r_cim   <= 1'b0;
      r_adc   <= 1'b0;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (err_clr) r_err <= 1'b0;
      r_dac <= 1'b0;
      r_cim <= 1'b0;
      r_adc <= 1'b0;
      case (r_state)
        S_IDLE: if (wl_in_valid) begin
          r_wl    <= wl_in;
          r_sel   <= '0;
          r_dac   <= 1'b1;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_cim   <= 1'b1;
          r_state <= S_CSTART;
        end
        S_CSTART: begin
          r_timer <= '0;
          r_state <= S_CWAIT;
        end
        S_CWAIT:
          if (cim_done) begin
            r_adc   <= 1'b1;
            r_state <= S_ASTART;
          end else if (r_timer == LP_TMAX) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else r_timer <= r_timer + 1'b1;
        S_ASTART: begin
          r_timer <= '0;
          r_state <= S_AWAIT;
        end
        S_AWAIT:
          if (adc_done) begin
            r_raw[r_sel] <= bl_data;
            if (r_sel == LP_LAST) r_state <= S_DIFF;
            else begin
              r_sel   <= r_sel + 1'b1;
              r_adc   <= 1'b1;
              r_state <= S_ASTART;
            end
          end else if (r_timer == LP_TMAX) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else r_timer <= r_timer + 1'b1;
        S_DIFF: begin
          for (int i = 0; i < P_NUM_OUTPUTS; i++)
            r_diff[i*LP_DW +: LP_DW] <= {1'b0, r_raw[i]} - {1'b0, r_raw[i+P_NUM_OUTPUTS]};
          r_dv    <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: if (diff_ready) begin
          r_dv    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_cim_timestep_sequencer.sv
// tb_cim_timestep_sequencer: scoreboard bench with a behavioural CIM macro for cim_timestep_sequencer
module tb_cim_timestep_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] wl_in = '0;
  logic        wl_in_valid = 1'b0;
  logic        wl_in_ready;
  logic [63:0] wl_spike;
  logic        dac_valid, cim_start, adc_start;
  logic        cim_done = 1'b0;
  logic        adc_done = 1'b0;
  logic [4:0]  bl_sel;
  logic [7:0]  bl_data = '0;
  logic        diff_valid;
  logic        diff_ready = 1'b1;
  logic [89:0] diff_data;
  logic        busy, err_timeout;
  logic        err_clr = 1'b0;
  int errors = 0, checks = 0, cyc = 0, last_done = 0;
  int n_dac = 0, n_cim = 0, n_adc = 0, exp_sel = 0;
  int cim_cnt = 0, adc_cnt = 0, adc_ch = 0;
  bit suppress = 0, stub = 0;
  logic prev_dv = 1'b0;
  logic [89:0] sb[$];
  cim_timestep_sequencer dut (
    .clk(clk), .rst_n(rst_n), .wl_in(wl_in), .wl_in_valid(wl_in_valid), .wl_in_ready(wl_in_ready),
    .wl_spike(wl_spike), .dac_valid(dac_valid), .cim_start(cim_start), .cim_done(cim_done),
    .adc_start(adc_start), .adc_done(adc_done), .bl_sel(bl_sel), .bl_data(bl_data),
    .diff_valid(diff_valid), .diff_ready(diff_ready), .diff_data(diff_data), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [89:0] pack(input logic [8:0] v);
    logic [89:0] r;
    for (int i = 0; i < 10; i++) r[i*9 +: 9] = v;
    return r;
  endfunction
  function automatic logic [7:0] model(input int ch);
    int p;
    p = $countones(wl_spike);
    if (stub) return ch < 10 ? 8'd10 : 8'd200;
    return ch < 10 ? 8'(2*p + ch) : 8'(p/2 + ch - 10);
  endfunction
  // Macro model: cim_done 3 cycles after cim_start, adc_done 2 cycles after adc_start.
  always @(negedge clk) begin
    cim_done = 1'b0;
    adc_done = 1'b0;
    if (!rst_n) begin
      cim_cnt = 0;
      adc_cnt = 0;
    end else begin
      if (cim_cnt > 0) begin
        cim_cnt--;
        if (cim_cnt == 0) cim_done = 1'b1;
      end
      if (adc_cnt > 0) begin
        adc_cnt--;
        if (adc_cnt == 0) begin
          adc_done = 1'b1;
          bl_data = model(adc_ch);
          chk("bl_sel_held", 128'(bl_sel), 128'(adc_ch));
          if (adc_ch == 19) last_done = cyc;
        end
      end
      if (dac_valid) begin
        n_dac++;
        exp_sel = 0;
      end
      if (cim_start) begin
        n_cim++;
        if (!suppress) cim_cnt = 3;
      end
      if (adc_start) begin
        n_adc++;
        chk("bl_sel_order", 128'(bl_sel), 128'(exp_sel));
        exp_sel++;
        adc_ch = int'(bl_sel);
        adc_cnt = 2;
      end
    end
  end
  always @(negedge clk) begin
    #1;
    if (rst_n && diff_valid && !prev_dv) chk("diff_latency", 128'(cyc - last_done), 128'd2);
    if (rst_n && diff_valid && diff_ready) begin
      if (sb.size() == 0) chk("unexpected_diff", 128'(diff_data), 128'hDEAD);
      else chk("diff_data", 128'(diff_data), 128'(sb.pop_front()));
    end
    prev_dv = diff_valid;
  end
  task automatic issue(input logic [63:0] wl);
    bit ok = 0;
    @(negedge clk);
    wl_in = wl;
    wl_in_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (wl_in_ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 128'd0, 128'd1);
    @(negedge clk);
    wl_in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) chk("idle_timeout", 128'd0, 128'd1);
  endtask
  task automatic plane(input logic [63:0] wl, input logic [8:0] v);
    int d0, c0, a0;
    d0 = n_dac; c0 = n_cim; a0 = n_adc;
    sb.push_back(pack(v));
    issue(wl);
    chk("wl_spike", 128'(wl_spike), 128'(wl));
    wait_idle();
    chk("dac_pulses", 128'(n_dac - d0), 128'd1);
    chk("cim_pulses", 128'(n_cim - c0), 128'd1);
    chk("adc_pulses", 128'(n_adc - a0), 128'd20);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(wl_in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_pulses", 128'({dac_valid, cim_start, adc_start, diff_valid, err_timeout}), 128'd0);
    chk("rst_bl_sel", 128'(bl_sel), 128'd0);
    chk("rst_diff", 128'(diff_data), 128'd0);
    chk("rst_wl_spike", 128'(wl_spike), 128'd0);
    rst_n = 1'b1;
    plane(64'hFFFF_FFFF_FFFF_FFFF, 9'd96);
    plane(64'h0, 9'd0);
    plane(64'h0F, 9'd6);
    stub = 1;
    plane(64'h1234_5678_9ABC_DEF0, 9'h142);
    stub = 0;
    diff_ready = 1'b0;
    sb.push_back(pack(9'd96));
    issue(64'hFFFF_FFFF_FFFF_FFFF);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (diff_valid) ok = 1;
    end
    if (!ok) chk("hold_valid_timeout", 128'd0, 128'd1);
    sb.push_back(pack(9'd0));
    wl_in = 64'h0;
    wl_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(diff_valid), 128'd1);
      chk("hold_data", 128'(diff_data), 128'(pack(9'd96)));
      chk("hold_ready_low", 128'(wl_in_ready), 128'd0);
    end
    diff_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (wl_in_ready) ok = 1;
    end
    if (!ok) chk("hold_release", 128'd0, 128'd1);
    @(negedge clk);
    wl_in_valid = 1'b0;
    chk("held_accept_busy", 128'(busy), 128'd1);
    wait_idle();
    suppress = 1;
    issue(64'hFFFF);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (cim_start) ok = 1;
    end
    if (!ok) chk("to_cim_start", 128'd0, 128'd1);
    repeat (255) @(negedge clk);
    chk("to_err_early", 128'(err_timeout), 128'd0);
    chk("to_busy_early", 128'(busy), 128'd1);
    @(negedge clk);
    chk("to_err", 128'(err_timeout), 128'd1);
    chk("to_idle", 128'(busy), 128'd0);
    suppress = 0;
    repeat (3) @(negedge clk);
    chk("to_sticky", 128'(err_timeout), 128'd1);
    chk("to_no_valid", 128'(diff_valid), 128'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 128'(err_timeout), 128'd0);
    plane(64'hFFFF_FFFF_FFFF_FFFF, 9'd96);
    issue(64'hFFFF_FFFF_FFFF_FFFF);
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (busy && bl_sel == 5'd7 && !adc_start) ok = 1;
    end
    if (!ok) chk("mid_await7", 128'd0, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(wl_in_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_bl_sel", 128'(bl_sel), 128'd0);
    chk("mid_rst_out", 128'({dac_valid, cim_start, adc_start, diff_valid, err_timeout}), 128'd0);
    chk("mid_rst_diff", 128'(diff_data), 128'd0);
    chk("mid_rst_wl", 128'(wl_spike), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    plane(64'hFFFF_FFFF_FFFF_FFFF, 9'd96);
    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
